// File: rtl/fft_post_pkg.sv
// Shared types and constants for the FFT post-processing stage.
// PEAK_SKIP_DC_EN: when defined, bin 0 is excluded from the peak search.
package fft_post_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } frm_state_e;

`ifdef PEAK_SKIP_DC_EN
  localparam int unsigned FirstBin = 1;
`else
  localparam int unsigned FirstBin = 0;
`endif

  // re^2 + im^2 of two signed w-bit values always fits in 2*w unsigned bits.
  function automatic int unsigned pwr_width(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/fft_cmag2.sv
// Three-stage magnitude-squared pipeline; en/cnt travel alongside the data.
module fft_cmag2 import fft_post_pkg::*; #(
  parameter int unsigned width = 16,
  parameter int unsigned NALL  = 9,
  localparam int unsigned PW   = pwr_width(width)
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    en,
  input  logic [NALL-1:0]         cnt,
  input  logic signed [width-1:0] re,
  input  logic signed [width-1:0] im,
  output logic                    pwr_en,
  output logic [NALL-1:0]         pwr_cnt,
  output logic [PW-1:0]           pwr_val
);

  logic                    en1_q, en2_q;
  logic [NALL-1:0]         cnt1_q, cnt2_q;
  logic signed [width-1:0] re1_q, im1_q;
  logic signed [PW-1:0]    re_w, im_w;
  logic signed [PW-1:0]    re_sq_q, im_sq_q;

  assign re_w = PW'(re1_q);
  assign im_w = PW'(im1_q);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      en1_q   <= 1'b0;
      cnt1_q  <= '0;
      re1_q   <= '0;
      im1_q   <= '0;
      en2_q   <= 1'b0;
      cnt2_q  <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      pwr_en  <= 1'b0;
      pwr_cnt <= '0;
      pwr_val <= '0;
    end else begin
      en1_q   <= en;
      cnt1_q  <= cnt;
      re1_q   <= re;
      im1_q   <= im;
      en2_q   <= en1_q;
      cnt2_q  <= cnt1_q;
      re_sq_q <= re_w * re_w;
      im_sq_q <= im_w * im_w;
      pwr_en  <= en2_q;
      pwr_cnt <= cnt2_q;
      // Both squares are non-negative; their sum peaks at 2^(PW-1).
      pwr_val <= $unsigned(re_sq_q) + $unsigned(im_sq_q);
    end
  end

endmodule

// File: rtl/fft_peak_search.sv
// Power stream plus per-frame peak bin search over the FFT output.
// PEAK_SKIP_DC_EN (see fft_post_pkg): exclude bin 0 from the peak search.
module fft_peak_search import fft_post_pkg::*; #(
  parameter int unsigned width     = 16,
  parameter int unsigned NALL      = 9,
  parameter int unsigned HALF_SPEC = 1,
  localparam int unsigned PW       = pwr_width(width)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             fft_en,
  input  logic [NALL-1:0]  fft_cnt,
  input  logic [width-1:0] fft_re,
  input  logic [width-1:0] fft_im,
  output logic             pwr_en,
  output logic [NALL-1:0]  pwr_cnt,
  output logic [PW-1:0]    pwr_val,
  output logic             pk_valid,
  output logic [NALL-1:0]  pk_bin,
  output logic [PW-1:0]    pk_pwr,
  output logic             frm_err
);

  localparam logic [NALL-1:0] LastBin = '1;
  localparam logic [NALL-1:0] SeedBin = NALL'(FirstBin);

  fft_cmag2 #(
    .width (width),
    .NALL  (NALL)
  ) u_cmag2 (
    .clk     (clk),
    .areset  (areset),
    .en      (fft_en),
    .cnt     (fft_cnt),
    .re      (fft_re),
    .im      (fft_im),
    .pwr_en  (pwr_en),
    .pwr_cnt (pwr_cnt),
    .pwr_val (pwr_val)
  );

  frm_state_e      state_q, state_d;
  logic [NALL-1:0] exp_q, exp_d;
  logic [NALL-1:0] best_bin_q, best_bin_d;
  logic [PW-1:0]   best_pwr_q, best_pwr_d;
  logic [NALL-1:0] pk_bin_d;
  logic [PW-1:0]   pk_pwr_d;
  logic            pk_valid_d, frm_err_d;
  logic            start, accept, elig, take;
  logic [NALL-1:0] base_bin, cand_bin;
  logic [PW-1:0]   base_pwr, cand_pwr;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    best_bin_d = best_bin_q;
    best_pwr_d = best_pwr_q;
    pk_bin_d   = pk_bin;
    pk_pwr_d   = pk_pwr;
    pk_valid_d = 1'b0;
    frm_err_d  = 1'b0;
    start      = 1'b0;
    accept     = 1'b0;

    if (pwr_en) begin
      unique case (state_q)
        StIdle: start = (pwr_cnt == '0);
        StAccum: begin
          if (pwr_cnt == exp_q) begin
            accept = 1'b1;
          end else begin
            // Sequence broken: drop the frame; a bin 0 immediately restarts.
            frm_err_d = 1'b1;
            start     = (pwr_cnt == '0);
            state_d   = StIdle;
          end
        end
        default: ;
      endcase
    end

    elig     = ((HALF_SPEC == 0) || !pwr_cnt[NALL-1]) && ((FirstBin == 0) || (pwr_cnt != '0));
    base_bin = start ? SeedBin : best_bin_q;
    base_pwr = start ? '0 : best_pwr_q;
    take     = elig && (pwr_val > base_pwr);
    cand_bin = take ? pwr_cnt : base_bin;
    cand_pwr = take ? pwr_val : base_pwr;

    if (start || accept) begin
      best_bin_d = cand_bin;
      best_pwr_d = cand_pwr;
      exp_d      = pwr_cnt + NALL'(1);
      state_d    = StAccum;
      if (accept && (pwr_cnt == LastBin)) begin
        pk_valid_d = 1'b1;
        pk_bin_d   = cand_bin;
        pk_pwr_d   = cand_pwr;
        state_d    = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      best_bin_q <= '0;
      best_pwr_q <= '0;
      pk_valid   <= 1'b0;
      pk_bin     <= '0;
      pk_pwr     <= '0;
      frm_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      best_bin_q <= best_bin_d;
      best_pwr_q <= best_pwr_d;
      pk_valid   <= pk_valid_d;
      pk_bin     <= pk_bin_d;
      pk_pwr     <= pk_pwr_d;
      frm_err    <= frm_err_d;
    end
  end

endmodule

// File: tb/tb_fft_peak_search.sv
// Randomized bench for fft_peak_search: half- and full-spectrum instances vs a frame-level model.
module tb_fft_peak_search;

  localparam int W  = 16;
  localparam int N  = 9;
  localparam int NB = 512;
  localparam int HB = 256;
`ifdef PEAK_SKIP_DC_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef struct {
    longint due;
    longint cnt;
    longint val;
  } pwr_t;

  typedef struct {
    longint due;
    longint bin_h;
    longint pwr_h;
    longint bin_f;
    longint pwr_f;
  } pk_t;

  logic           clk = 1'b0;
  logic           areset;
  logic           fft_en;
  logic [N-1:0]   fft_cnt;
  logic [W-1:0]   fft_re, fft_im;
  logic           pwr_en_h, pwr_en_f, pk_valid_h, pk_valid_f, frm_err_h, frm_err_f;
  logic [N-1:0]   pwr_cnt_h, pwr_cnt_f, pk_bin_h, pk_bin_f;
  logic [2*W-1:0] pwr_val_h, pwr_val_f, pk_pwr_h, pk_pwr_f;

  fft_peak_search #(.width(W), .NALL(N), .HALF_SPEC(1)) dut_h (
    .clk(clk), .areset(areset), .fft_en(fft_en), .fft_cnt(fft_cnt), .fft_re(fft_re),
    .fft_im(fft_im), .pwr_en(pwr_en_h), .pwr_cnt(pwr_cnt_h), .pwr_val(pwr_val_h),
    .pk_valid(pk_valid_h), .pk_bin(pk_bin_h), .pk_pwr(pk_pwr_h), .frm_err(frm_err_h)
  );

  fft_peak_search #(.width(W), .NALL(N), .HALF_SPEC(0)) dut_f (
    .clk(clk), .areset(areset), .fft_en(fft_en), .fft_cnt(fft_cnt), .fft_re(fft_re),
    .fft_im(fft_im), .pwr_en(pwr_en_f), .pwr_cnt(pwr_cnt_f), .pwr_val(pwr_val_f),
    .pk_valid(pk_valid_f), .pk_bin(pk_bin_f), .pk_pwr(pk_pwr_f), .frm_err(frm_err_f)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expectations keyed by the cycle they must appear.
  pwr_t   pq[$];
  pk_t    kq[$];
  longint eq[$];
  bit     in_frame;
  longint expct, bh_p, bf_p, bh_b, bf_b;
  longint held_bin_h, held_pwr_h, held_bin_f, held_pwr_f;
  int     err_seen = 0, pk_seen = 0;
  int     re_a[NB], im_a[NB];

  function automatic void model_reset();
    pq.delete(); kq.delete(); eq.delete();
    in_frame = 0; expct = 0;
    held_bin_h = 0; held_pwr_h = 0; held_bin_f = 0; held_pwr_f = 0;
  endfunction

  function automatic void model_sample(longint due, int c, int re, int im);
    longint p;
    bit     start, ok;
    p = longint'(re) * re + longint'(im) * im;
    pq.push_back('{due, longint'(c), p});
    start = 0;
    ok    = 0;
    if (!in_frame) start = (c == 0);
    else if (c == expct) ok = 1;
    else begin
      eq.push_back(due + 1);
      in_frame = 0;
      start    = (c == 0);
    end
    if (start) begin
      in_frame = 1; ok = 1;
      bh_p = 0; bf_p = 0; bh_b = FIRST; bf_b = FIRST;
    end
    if (ok) begin
      if (c >= FIRST && c < HB && p > bh_p) begin bh_p = p; bh_b = c; end
      if (c >= FIRST && p > bf_p) begin bf_p = p; bf_b = c; end
      expct = c + 1;
      if (c == NB - 1) begin
        kq.push_back('{due + 1, bh_b, bh_p, bf_b, bf_p});
        in_frame = 0;
      end
    end
  endfunction

  always @(negedge clk) begin : mon
    pwr_t pe;
    pk_t  ke;
    bit   exp_pk, exp_err;
    if (frm_err_h) err_seen++;
    if (pk_valid_h) pk_seen++;
    if (pq.size() != 0 && pq[0].due == cyc) begin
      pe = pq.pop_front();
      check_eq("pwr_en_h", 64'(pwr_en_h), 1);
      check_eq("pwr_en_f", 64'(pwr_en_f), 1);
      check_eq("pwr_cnt_h", 64'(pwr_cnt_h), pe.cnt);
      check_eq("pwr_cnt_f", 64'(pwr_cnt_f), pe.cnt);
      check_eq("pwr_val_h", 64'(pwr_val_h), pe.val);
      check_eq("pwr_val_f", 64'(pwr_val_f), pe.val);
    end else begin
      check_eq("pwr_en_idle_h", 64'(pwr_en_h), 0);
      check_eq("pwr_en_idle_f", 64'(pwr_en_f), 0);
    end
    exp_pk = 0;
    if (kq.size() != 0 && kq[0].due == cyc) begin
      ke = kq.pop_front();
      exp_pk = 1;
      held_bin_h = ke.bin_h; held_pwr_h = ke.pwr_h;
      held_bin_f = ke.bin_f; held_pwr_f = ke.pwr_f;
    end
    check_eq("pk_valid_h", 64'(pk_valid_h), longint'(exp_pk));
    check_eq("pk_valid_f", 64'(pk_valid_f), longint'(exp_pk));
    check_eq("pk_bin_h", 64'(pk_bin_h), held_bin_h);
    check_eq("pk_pwr_h", 64'(pk_pwr_h), held_pwr_h);
    check_eq("pk_bin_f", 64'(pk_bin_f), held_bin_f);
    check_eq("pk_pwr_f", 64'(pk_pwr_f), held_pwr_f);
    exp_err = 0;
    if (eq.size() != 0 && eq[0] == cyc) begin
      void'(eq.pop_front());
      exp_err = 1;
    end
    check_eq("frm_err_h", 64'(frm_err_h), longint'(exp_err));
    check_eq("frm_err_f", 64'(frm_err_f), longint'(exp_err));
  end

  task automatic drive(input bit en, input int c, input int re, input int im);
    @(posedge clk);
    #1;
    fft_en  = en;
    fft_cnt = c[N-1:0];
    fft_re  = re[W-1:0];
    fft_im  = im[W-1:0];
    if (en) model_sample(longint'(cyc) + 3, c, re, im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < NB; i++) begin re_a[i] = 0; im_a[i] = 0; end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        re_a[i] = rnd_s16(); im_a[i] = rnd_s16();
      end else begin
        re_a[i] = int'($urandom_range(0, 100)) - 50; im_a[i] = int'($urandom_range(0, 100)) - 50;
      end
    end
  endtask

  task automatic drive_frame(input int skip, input bit gaps, input int nbins);
    for (int c = 0; c < nbins; c++) begin
      if (c != skip) begin
        if (gaps && $urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) drive(0, int'($urandom_range(0, NB - 1)), rnd_s16(), rnd_s16());
        drive(1, c, re_a[c], im_a[c]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pwr_en"}, 64'(pwr_en_h | pwr_en_f), 0);
    check_eq({tag, "_pwr_cnt"}, 64'(pwr_cnt_h | pwr_cnt_f), 0);
    check_eq({tag, "_pwr_val"}, 64'(pwr_val_h | pwr_val_f), 0);
    check_eq({tag, "_pk_valid"}, 64'(pk_valid_h | pk_valid_f), 0);
    check_eq({tag, "_pk_bin"}, 64'(pk_bin_h | pk_bin_f), 0);
    check_eq({tag, "_pk_pwr"}, 64'(pk_pwr_h | pk_pwr_f), 0);
    check_eq({tag, "_frm_err"}, 64'(frm_err_h | frm_err_f), 0);
  endtask

  task automatic check_peak(input string tag, input longint bh, input longint ph,
                            input longint bf, input longint pf);
    check_eq({tag, "_bin_h"}, 64'(pk_bin_h), bh);
    check_eq({tag, "_pwr_h"}, 64'(pk_pwr_h), ph);
    check_eq({tag, "_bin_f"}, 64'(pk_bin_f), bf);
    check_eq({tag, "_pwr_f"}, 64'(pk_pwr_f), pf);
  endtask

  int e0, p0;

  initial begin
    areset = 1'b1; fft_en = 1'b0; fft_cnt = '0; fft_re = '0; fft_im = '0;
    model_reset();
    #1;
    check_outputs_zero("rst");
    repeat (3) @(posedge clk);
    #2 areset = 1'b0;

    // Single tone
    clear_frame(); re_a[37] = 1000; im_a[37] = -500;
    drive_frame(-1, 0, NB); idle(6);
    check_peak("tone", 37, 1250000, 37, 1250000);

    // Tie keeps the lower bin; the mirror bin only counts for the full spectrum
    clear_frame();
    re_a[10] = 300; im_a[10] = 400; re_a[20] = 300; im_a[20] = 400; re_a[475] = 2000;
    drive_frame(-1, 0, NB); idle(6);
    check_peak("tie", 10, 250000, 475, 4000000);

    // Most negative inputs
    clear_frame(); re_a[5] = -32768; im_a[5] = -32768;
    drive_frame(-1, 0, NB); idle(6);
    check_peak("ext", 5, 64'h8000_0000, 5, 64'h8000_0000);

    // DC handling
    clear_frame(); re_a[0] = 5000; re_a[3] = 100;
    drive_frame(-1, 0, NB); idle(6);
    if (FIRST == 1) check_peak("dc", 3, 10000, 3, 10000);
    else check_peak("dc", 0, 25000000, 0, 25000000);

    // All-zero frame reports the first eligible bin
    clear_frame();
    drive_frame(-1, 0, NB); idle(6);
    check_peak("zero", FIRST, 0, FIRST, 0);

    // Back-to-back random frames, with and without gaps
    rand_frame(); drive_frame(-1, 1, NB);
    rand_frame(); drive_frame(-1, 0, NB);
    rand_frame(); drive_frame(-1, 0, NB); idle(6);

    // Reset in the middle of a frame
    rand_frame(); drive_frame(-1, 0, 200);
    @(posedge clk);
    #3;
    areset = 1'b1; fft_en = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("mid_rst");
    repeat (2) @(posedge clk);
    #2 areset = 1'b0;
    p0 = pk_seen;
    rand_frame(); drive_frame(-1, 0, NB); idle(6);
    check_eq("post_rst_pk_count", 64'(pk_seen - p0), 1);

    // Skipped bin, then an immediate clean frame with gaps
    e0 = err_seen; p0 = pk_seen;
    rand_frame(); drive_frame(100, 0, NB);
    rand_frame(); drive_frame(-1, 1, NB); idle(6);
    check_eq("seq_err_count", 64'(err_seen - e0), 1);
    check_eq("seq_pk_count", 64'(pk_seen - p0), 1);

    // Restart on bin 0 mid-frame
    e0 = err_seen;
    rand_frame(); drive_frame(-1, 0, 300);
    rand_frame(); drive_frame(-1, 1, NB); idle(6);
    check_eq("restart_err_count", 64'(err_seen - e0), 1);

    check_eq("queues_drained", 64'(pq.size() + kq.size() + eq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_search.md
# fft_peak_search

Downstream post-processing stage for the radix-2 pipelined FFT core. Consumes the per-bin complex output stream (enable, bin index, re, im) and computes the magnitude-squared of every bin. Re-emits that power as a stream and, once per complete frame, reports the bin with the largest power. The results drive spectrum logging and tone-frequency readout on the FPGA.

## Interface
- width, 16, bit width of signed FFT re/im samples
- NALL, 9, log2 of FFT length (frame = 2**NALL bins)
- HALF_SPEC, 1, when 1 only bins 0..2**(NALL-1)-1 are eligible for peak search (real-input spectrum)
- clk  input  1  single clock, all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- fft_en  input  1  bin sample valid this cycle
- fft_cnt  input  NALL  bin index of current sample, natural order 0..2**NALL-1
- fft_re  input  width  signed real part
- fft_im  input  width  signed imaginary part
- pwr_en  output  1  power sample valid
- pwr_cnt  output  NALL  bin index of pwr_val
- pwr_val  output  2*width  unsigned re²+im²
- pk_valid  output  1  one-cycle pulse, peak result valid
- pk_bin  output  NALL  index of peak bin (held until next pk_valid)
- pk_pwr  output  2*width  power of peak bin (held)
- frm_err  output  1  one-cycle pulse, frame sequence error

## Operation
- Power pipeline, 3 register stages: S1 registers en/cnt/re/im; S2 registers re², im² (signed products, 2*width bits); S3 registers unsigned sum. Width 2*width always suffices: worst case 2·(−2^(width−1))² = 2^(2*width−1). No saturation, no rounding.
- Frame tracker on S3 output, states IDLE and ACCUM:
  - IDLE: pwr_en with pwr_cnt==0 → ACCUM, expected=1, best seeded. Other indices are ignored silently.
  - ACCUM: a pwr_en with pwr_cnt==expected → compare, expected+1. A pwr_en with pwr_cnt==2**NALL-1 → pk_valid next cycle, go to IDLE.
  - ACCUM: a pwr_en with pwr_cnt≠expected → frm_err pulse, best discarded, no pk_valid. If that sample's cnt==0 it starts a new frame (stay ACCUM, expected=1); otherwise go to IDLE.
  - Gaps (pwr_en low) are allowed anywhere without penalty.
- Best register: seeded at frame start with pwr=0, bin=first eligible index. It is updated only when an eligible bin has pwr > best pwr (strict), so ties keep the lower index. An all-zero frame reports the first eligible index with power 0.
- Eligibility: bin < 2**(NALL-1) when HALF_SPEC=1, otherwise all bins. Ineligible bins still advance the sequence check.

## Timing
- Reset values: pwr_en=0, pwr_cnt=0, pwr_val=0, pk_valid=0, pk_bin=0, pk_pwr=0, frm_err=0, state IDLE, pipeline valids cleared.
- Input sampled at edge t → pwr_* valid after edge t+3.
- Last bin sampled at edge t → pk_valid, pk_bin, pk_pwr updated at edge t+4. frm_err asserts at the same relative latency (t+4) for the offending sample.
- Full throughput: one bin per clock. Back-to-back frames work with zero gap: a cnt==0 in the cycle right after cnt==2**NALL-1 starts the next frame.
- Reset mid-frame discards partial frame and pipeline contents. pk_* return to 0.

## Configuration
- PEAK_SKIP_DC_EN defined: bin 0 is ineligible and the best register is seeded with bin=1. Bin 0 still starts the frame and passes through the power stream.
- Not defined: bin 0 is eligible and the seed bin is 0.

## Structure
- Package fft_post_pkg: function for power width (2*width), state encoding constants (IDLE, ACCUM), first-eligible-bin constant derived from PEAK_SKIP_DC_EN.
- Sub-module fft_cmag2: the 3-stage magnitude-squared pipeline carrying en/cnt alongside the data. The top module holds the frame FSM and best register.

## Test plan
- Reset: assert areset asynchronously mid-frame (width=16, NALL=9) → all outputs 0 immediately, no pk_valid for the interrupted frame. The next full frame is reported normally.
- Single tone: full frame with bin 37 = (1000, −500), others 0 → pwr_val 1250000 at bin 37, pk_bin=37, pk_pwr=1250000 four cycles after bin 511.
- Tie and mirror: bins 10 and 20 = (300, 400), bin 475 = (2000, 0), HALF_SPEC=1 → pk_bin=10, pk_pwr=250000. With HALF_SPEC=0 → pk_bin=475, pk_pwr=4000000.
- Extremes: bin 5 = (−32768, −32768) → pwr_val=2147483648 (0x80000000), pk_bin=5.
- Sequence error: bin 100 skipped (cnt jumps 99→101) → single frm_err pulse, no pk_valid. An immediately following clean frame with random gaps in fft_en → correct pk_valid.
- DC: bin 0 = (5000, 0), bin 3 = (100, 0) → pk_bin=0 without PEAK_SKIP_DC_EN. With the macro defined → pk_bin=3, pk_pwr=10000.
